// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg: shared widths, fetch entry/state types and the NOP encoding
package inst_fetch_ctrl_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  misalign;
    } fetch_entry_t;
    typedef enum logic [1:0] {FC_IDLE, FC_RUN, FC_HALT} fetch_state_t;
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if: fetch control bus (redirect/halt in, inst_mem address/data, decode valid/ready out)
// master = fetch controller side, slave = execute/inst_mem/decode side
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_inst;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_inst;
    logic                  out_misalign;
    modport master (
        input  redirect_valid, redirect_pc, halt, imem_inst, out_ready,
        output imem_addr, out_valid, out_pc, out_inst, out_misalign
    );
    modport slave (
        output redirect_valid, redirect_pc, halt, imem_inst, out_ready,
        input  imem_addr, out_valid, out_pc, out_inst, out_misalign
    );
endinterface

// File: rtl/inst_fetch_ctrl_fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch entries with push/pop/flush and same-cycle push+pop
// ports: clk, rst_n, push/push_data, pop, flush in; head, valid, count out
// head holds the last presented entry while empty
module fetch_fifo import inst_fetch_ctrl_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    fetch_entry_t mem [DEPTH];
    fetch_entry_t held;
    logic [PW-1:0] rd_ptr, wr_ptr;
    assign valid = count != '0;
    assign head = valid ? mem[rd_ptr] : held;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else begin
            if (valid) held <= mem[rd_ptr];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the PC, issues inst_mem fetches, aligns responses and buffers them for decode
// ports: clk, rst_n (async active-low), bus (inst_fetch_ctrl_if.master: redirect/halt, imem, decode handshake)
module inst_fetch_ctrl import inst_fetch_ctrl_pkg::*; #(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    inst_fetch_ctrl_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_t state, state_nxt;
    logic fault, fault_nxt;
    logic [ADDR_WIDTH-1:0] pc, inflight_pc;
    logic inflight, inflight_mis;
    logic [CW-1:0] count, occ;
    logic pop, issue, capture, mis;
    fetch_entry_t head, push_data;
    assign pop = bus.out_valid & bus.out_ready;
    // occupancy counts the in-flight word so a full FIFO can never be overrun by a late response
    assign occ = count + CW'(inflight) - CW'(pop);
    assign mis = pc[1:0] != 2'b00;
    assign issue = (state == FC_RUN) && !bus.halt && !bus.redirect_valid && (occ < CW'(FIFO_DEPTH));
    assign capture = inflight && !bus.redirect_valid;
    assign push_data = '{pc: inflight_pc, inst: inflight_mis ? INST_NOP : bus.imem_inst, misalign: inflight_mis};
    assign bus.imem_addr = pc;
    assign {bus.out_pc, bus.out_inst, bus.out_misalign} = head;
    always_comb begin
        state_nxt = state;
        fault_nxt = bus.redirect_valid ? 1'b0 : (fault | (issue & mis));
        state_nxt = (state == FC_IDLE) ? FC_RUN :
                    (state == FC_RUN)  ? ((!bus.redirect_valid && (bus.halt || (issue && mis))) ? FC_HALT : FC_RUN) :
                    ((!bus.halt && (bus.redirect_valid || !fault)) ? FC_RUN : FC_HALT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FC_IDLE;
            fault        <= 1'b0;
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            inflight_mis <= 1'b0;
        end else begin
            state    <= state_nxt;
            fault    <= fault_nxt;
            pc       <= bus.redirect_valid ? bus.redirect_pc : issue ? pc + ADDR_WIDTH'(4) : pc;
            inflight <= issue;
            if (issue) begin
                inflight_pc  <= pc;
                inflight_mis <= mis;
            end
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .valid     (bus.out_valid),
        .count     (count)
    );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: vector table plus scoreboard for the fetch controller
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;
    typedef struct {
        bit ready;
        bit valid;
        int pc;
        int addr;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int fails = 0;
    int acc = 0;
    fetch_entry_t exp_q [$];
    inst_fetch_ctrl_if bus();
    inst_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction
    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc = pc;
        e.misalign = pc[1:0] != 2'b00;
        e.inst = e.misalign ? INST_NOP : mem_word(pc);
        return e;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    task automatic run(input int n);
        repeat (n) next();
    endtask
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!bus.out_valid && n < limit) begin
            next();
            @(negedge clk);
            n++;
        end
    endtask
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.imem_inst <= '0;
        else bus.imem_inst <= mem_word(bus.imem_addr);
    end
    always @(negedge clk) begin : mon
        fetch_entry_t e;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                acc++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got pc %h expected no entry", bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.out_pc, e.pc);
                    chk("sb_inst", bus.out_inst, e.inst);
                    chk("sb_mis", 32'(bus.out_misalign), 32'(e.misalign));
                    if (!e.misalign) exp_q.push_back(mk(e.pc + 32'd4));
                end
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(mk(bus.redirect_pc));
            end
        end
    end
    initial begin
        vec_t vec [20];
        int n;
        int acc0;
        logic [31:0] a;
        vec = '{'{1'b1, 1'b0, 0, 0},   '{1'b1, 1'b0, 0, 0},   '{1'b1, 1'b0, 0, 4},   '{1'b1, 1'b1, 0, 8},
                '{1'b1, 1'b1, 4, 12},  '{1'b1, 1'b1, 8, 16},  '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20},
                '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20},
                '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20}, '{1'b0, 1'b1, 12, 20},
                '{1'b1, 1'b1, 12, 20}, '{1'b1, 1'b1, 16, 24}, '{1'b1, 1'b1, 20, 28}, '{1'b1, 1'b1, 24, 32}};
        bus.out_ready = 1'b1;
        bus.halt = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        exp_q.push_back(mk(32'h0));
        #2 rst_n = 1'b0;
        run(3);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_inst", bus.out_inst, 0);
        chk("rst_mis", 32'(bus.out_misalign), 0);
        // startup latency, steady stream, 10-cycle stall and release
        for (int c = 0; c < 20; c++) begin
            next();
            rst_n = 1'b1;
            bus.out_ready = vec[c].ready;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", c), 32'(bus.out_valid), 32'(vec[c].valid));
            chk($sformatf("vec%0d_pc", c), bus.out_pc, vec[c].pc);
            chk($sformatf("vec%0d_addr", c), bus.imem_addr, vec[c].addr);
        end
        // redirect while FIFO full
        next();
        bus.out_ready = 1'b0;
        run(4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        next();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(bus.out_valid), 0);
        wait_valid(8, n);
        chk("redir_latency", n, 2);
        chk("redir_pc", bus.out_pc, 32'h100);
        // redirect mid-stream with a fetch in flight and a pop in the same cycle
        run(5);
        acc0 = acc;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h180;
        next();
        bus.redirect_valid = 1'b0;
        run(6);
        chk("redir_stream_accepts", acc - acc0, 5);
        // misaligned redirect stops issue until the next redirect
        acc0 = acc;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        next();
        bus.redirect_valid = 1'b0;
        run(7);
        @(negedge clk);
        chk("mis_accepts", acc - acc0, 2);
        chk("mis_valid_after", 32'(bus.out_valid), 0);
        chk("mis_hold_pc", bus.out_pc, 32'h102);
        chk("mis_hold_inst", bus.out_inst, 32'h13);
        chk("mis_hold_flag", 32'(bus.out_misalign), 1);
        chk("mis_addr", bus.imem_addr, 32'h106);
        next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        next();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        wait_valid(8, n);
        chk("mis_recover_latency", n, 2);
        chk("mis_recover_pc0", bus.out_pc, 32'h200);
        next();
        @(negedge clk);
        chk("mis_recover_valid1", 32'(bus.out_valid), 1);
        chk("mis_recover_pc1", bus.out_pc, 32'h204);
        // halt for 5 cycles mid-stream
        run(4);
        acc0 = acc;
        bus.halt = 1'b1;
        @(negedge clk);
        a = bus.imem_addr;
        repeat (4) begin
            next();
            @(negedge clk);
        end
        chk("halt_accepts", acc - acc0, 2);
        chk("halt_valid", 32'(bus.out_valid), 0);
        chk("halt_pc_hold", bus.imem_addr, a);
        next();
        bus.halt = 1'b0;
        @(negedge clk);
        wait_valid(10, n);
        chk("halt_resume_latency", n, 3);
        chk("halt_resume_pc", bus.out_pc, a);
        // asynchronous reset with a non-empty FIFO
        run(3);
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_addr", bus.imem_addr, 0);
        chk("arst_pc", bus.out_pc, 0);
        exp_q.delete();
        exp_q.push_back(mk(32'h0));
        next();
        rst_n = 1'b1;
        @(negedge clk);
        wait_valid(10, n);
        chk("arst_restart_latency", n, 3);
        chk("arst_restart_pc", bus.out_pc, 0);
        acc0 = acc;
        run(5);
        chk("arst_restart_accepts", acc - acc0, 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
